uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx transmitter among NUM_REQ byte requesters.
- Grants one requester, latches its byte and holds that byte stable on tx_data for the whole frame. The transmitter samples its data input live, so the byte must not change mid-frame.
- Pulses tx_send once, then tracks tx_busy through the frame before arbitrating again.
- Sits between the logging/command sources and the uart_tx instance.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int DATA_BITS_DEFAULT = 8;

    function automatic int baud_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;

    logic [CW-1:0] cand;

    // One extra bit holds ptr+k before wrapping, so non-power-of-two N wraps correctly.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         active,
    output logic                         frame_done,
    output logic                         timeout_err,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_send,
    input  logic                         tx_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic                 active_q, active_d;
    logic                 frame_done_q, frame_done_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [DATA_BITS-1:0] pick_data;

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // A busy transmitter in IDLE belongs to someone else's frame, so no grant until it clears.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        grant_id_d    = grant_id_q;
        active_d      = active_q;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        tx_data_d     = tx_data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid && !tx_busy) begin
                    tx_data_d  = pick_data;
                    grant_id_d = pick_idx;
                    ack_d      = NUM_REQ'(1) << pick_idx;
                    active_d   = 1'b1;
                    ptr_d      = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    active_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    frame_done_d = 1'b1;
                    active_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            grant_id_q    <= '0;
            active_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign tx_data     = tx_data_q;
    assign tx_send     = (state_q == SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner sequences and a random phase,
// all checked against a round-robin model and a behavioural uart_tx stand-in.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR        = 4;
    localparam int DB        = 8;
    localparam int BT        = 16;
    localparam int BITC      = baud_cycles(1_600_000, 100_000);
    localparam int FRAME_CYC = 10 * BITC;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        active;
    logic        frame_done;
    logic        timeout_err;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;

    logic        uart_en;
    logic        busy_force;
    int          m_phase;
    int          m_cnt;
    logic        m_busy;
    logic        m_done;
    logic [7:0]  m_rx;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [3:0]  req_seen;
    logic [31:0] data_seen;
    logic [7:0]  exp_bytes[$];
    logic [7:0]  cur_byte;
    int          open_frames;
    int          model_ptr;
    int          stab_err;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_g;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[6];

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .DATA_BITS(DB),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant_id   (grant_id),
        .active     (active),
        .frame_done (frame_done),
        .timeout_err(timeout_err),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign tx_busy = uart_en ? m_busy : busy_force;

    // Stand-in uart_tx: takes tx_send in idle, raises busy one cycle later, reads tx_data live bit by bit.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_rx    <= 8'h00;
        end else begin
            m_done <= 1'b0;
            case (m_phase)
                0: if (uart_en && tx_send) m_phase <= 1;
                1: begin
                    m_busy  <= 1'b1;
                    m_cnt   <= 0;
                    m_rx    <= 8'h00;
                    m_phase <= 2;
                end
                default: begin
                    if (m_cnt >= BITC && m_cnt < 9 * BITC && (m_cnt % BITC) == BITC / 2)
                        m_rx[m_cnt / BITC - 1] <= tx_data[m_cnt / BITC - 1];
                    if (m_cnt == FRAME_CYC - 1) begin
                        m_busy  <= 1'b0;
                        m_done  <= 1'b1;
                        m_phase <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            endcase
        end
    end

    always @(posedge clock) begin
        req_seen  <= req;
        data_seen <= req_data;
    end

    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        req_data = d;
        req      = r;
    endtask

    task automatic waitAck(output logic [3:0] a);
        int c;
        a = 4'h0;
        for (c = 0; c < 600; c++) begin
            @(negedge clock);
            if (ack != 4'h0) begin
                a = ack;
                break;
            end
        end
        if (c == 600) checkOutput("ack_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic waitEnd(output logic fd, output logic te);
        int c;
        fd = 1'b0;
        te = 1'b0;
        for (c = 0; c < 600; c++) begin
            @(negedge clock);
            if (frame_done || timeout_err) begin
                fd = frame_done;
                te = timeout_err;
                break;
            end
        end
        if (c == 600) checkOutput("end_wait_expired", 32'd0, 32'd1);
    endtask

    // Scoreboard: every grant is predicted from the request vector the arbiter saw.
    always @(negedge clock) begin
        int g;
        logic [3:0] exp_mask;
        if (reset) begin
            exp_bytes.delete();
            open_frames = 0;
            model_ptr   = 0;
            stab_err    = 0;
        end else begin
            if (tx_send || ack != 4'h0)
                checkOutput("send_with_ack", 32'(tx_send), 32'(ack != 4'h0));
            if (ack != 4'h0) begin
                g        = model_pick(req_seen, model_ptr);
                exp_mask = (g < 0) ? 4'h0 : 4'(1 << g);
                checkOutput("arb_pick", 32'(ack), 32'(exp_mask));
                checkOutput("no_overlap", 32'(open_frames), 32'd0);
                if (g >= 0) begin
                    checkOutput("grant_id_model", 32'(grant_id), 32'(g));
                    cur_byte = data_seen[g*8 +: 8];
                    checkOutput("tx_data_latch", 32'(tx_data), 32'(cur_byte));
                    exp_bytes.push_back(cur_byte);
                    model_ptr = (g + 1) % NR;
                end
                open_frames++;
                stab_err = 0;
            end else if (open_frames > 0 && tx_data !== cur_byte) begin
                stab_err++;
            end
            if (m_done) begin
                if (exp_bytes.size() > 0) checkOutput("uart_decode", 32'(m_rx), 32'(exp_bytes.pop_front()));
                else checkOutput("uart_unexpected_frame", 32'd1, 32'd0);
            end
            if (frame_done || timeout_err) begin
                checkOutput("end_one_open_frame", 32'(open_frames), 32'd1);
                checkOutput("inactive_at_end", 32'(active), 32'd0);
                checkOutput("tx_data_stable", 32'(stab_err), 32'd0);
                if (timeout_err && exp_bytes.size() > 0) void'(exp_bytes.pop_front());
                open_frames = (open_frames > 0) ? open_frames - 1 : 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] a;
        logic fd, te;
        int k, n;

        reset      = 1'b0;
        req        = 4'h0;
        req_data   = 32'h0;
        uart_en    = 1'b1;
        busy_force = 1'b0;

        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{4'b0011, 32'h0000_C311, 0, 8'h11};
        vecs[2] = '{4'b1001, 32'h7E00_0009, 3, 8'h7E};
        vecs[3] = '{4'b1111, 32'hD4C3_B2A1, 0, 8'hA1};
        vecs[4] = '{4'b0001, 32'h0000_00F0, 0, 8'hF0};
        vecs[5] = '{4'b1000, 32'h5B00_0000, 3, 8'h5B};

        #2 reset = 1'b1;
        #1;
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] vector table");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].req, vecs[v].data);
            waitAck(a);
            checkOutput("vec_ack", 32'(a), 32'(1 << vecs[v].exp_g));
            checkOutput("vec_grant_id", 32'(grant_id), 32'(vecs[v].exp_g));
            checkOutput("vec_tx_data", 32'(tx_data), 32'(vecs[v].exp_byte));
            checkOutput("vec_tx_send", 32'(tx_send), 32'd1);
            checkOutput("vec_active", 32'(active), 32'd1);
            req = 4'h0;
            waitEnd(fd, te);
            checkOutput("vec_frame_done", 32'(fd), 32'd1);
            checkOutput("vec_tx_data_end", 32'(tx_data), 32'(vecs[v].exp_byte));
        end

        $display("[TB] round-robin fairness");
        applyStimulus(4'hF, 32'h4332_2110);
        for (int f = 0; f < 8; f++) begin
            waitAck(a);
            checkOutput("rr_order", 32'(a), 32'(1 << (f % 4)));
            if (f == 7) req = 4'h0;
            waitEnd(fd, te);
            checkOutput("rr_frame_done", 32'(fd), 32'd1);
        end

        $display("[TB] data stability");
        applyStimulus(4'b0010, 32'h0000_3C00);
        waitAck(a);
        checkOutput("stab_ack", 32'(a), 32'd2);
        req = 4'h0;
        n = 0;
        fd = 1'b0;
        for (k = 0; k < 600 && !fd; k++) begin
            req_data[15:8] = 8'($urandom);
            @(negedge clock);
            if (active && tx_data !== 8'h3C) n++;
            fd = frame_done;
        end
        checkOutput("stab_frame_done", 32'(fd), 32'd1);
        checkOutput("stab_tx_data", 32'(n), 32'd0);

        $display("[TB] busy timeout");
        uart_en    = 1'b0;
        busy_force = 1'b0;
        applyStimulus(4'b0001, 32'h0000_00E7);
        waitAck(a);
        checkOutput("to_ack", 32'(a), 32'd1);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!timeout_err && k < 40);
        // ack shows in the tx_send cycle; the wait for busy starts one cycle later.
        checkOutput("to_latency", 32'(k), 32'(BT + 1));
        checkOutput("to_active_low", 32'(active), 32'd0);
        @(negedge clock);
        checkOutput("to_regrant", 32'(ack), 32'd1);
        req = 4'h0;
        waitEnd(fd, te);
        checkOutput("to_second_timeout", 32'(te), 32'd1);

        $display("[TB] busy-at-idle guard");
        busy_force = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0066);
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (ack != 4'h0) n++;
        end
        checkOutput("guard_no_ack", 32'(n), 32'd0);
        busy_force = 1'b0;
        @(negedge clock);
        checkOutput("guard_ack", 32'(ack), 32'd1);
        req = 4'h0;
        waitEnd(fd, te);
        checkOutput("guard_timeout", 32'(te), 32'd1);

        $display("[TB] reset mid-frame");
        uart_en = 1'b1;
        applyStimulus(4'b0010, 32'h7700_5A00);
        waitAck(a);
        checkOutput("rst_pre_ack", 32'(a), 32'd2);
        req = 4'b1000;
        k = 0;
        while (!tx_busy && k < 20) begin
            @(negedge clock);
            k++;
        end
        checkOutput("rst_busy_seen", 32'(tx_busy), 32'd1);
        repeat (40) @(negedge clock);
        checkOutput("rst_pre_active", 32'(active), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_active", 32'(active), 32'd0);
        checkOutput("rst_mid_ack", 32'(ack), 32'd0);
        checkOutput("rst_mid_tx_send", 32'(tx_send), 32'd0);
        checkOutput("rst_mid_tx_data", 32'(tx_data), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        waitAck(a);
        checkOutput("rst_regrant", 32'(a), 32'd8);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd3);
        req = 4'h0;
        waitEnd(fd, te);
        checkOutput("rst_frame_done", 32'(fd), 32'd1);

        $display("[TB] random traffic");
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            for (int i = 0; i < NR; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && c < 3600 && $urandom_range(0, 99) < 4) begin
                    req_data[i*8 +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 199) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = 4'h0;
        k = 0;
        while ((active || ack != 4'h0) && k < 600) begin
            @(negedge clock);
            k++;
        end
        repeat (3) @(negedge clock);
        checkOutput("final_idle", 32'(active), 32'd0);
        checkOutput("final_no_open_frame", 32'(open_frames), 32'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
